pattern_scan_ctrl: RTL
======================

# pattern_scan_ctrl

Programmable sequence-scan controller for the 3-bit symbol stream used by the sequence-recognizer blocks. A host loads a pattern of up to MAX_LEN symbols and a match limit, then arms the block. The block consumes qualified input symbols, tracks match progress, pulses on every complete match and counts matches, and stops by itself when the limit is reached. It sits between the symbol source and the host/control logic, replacing a fixed-pattern recognizer with one whose pattern and run length are configured at run time.

## Interface
- SYM_W, 3, symbol width in bits
- MAX_LEN, 4, maximum pattern length in symbols
- CNT_W, 8, width of match counter and limit

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cfg_we  in  1  write pattern symbol cfg_sym to slot cfg_addr
- cfg_addr  in  2  pattern slot index, 0..MAX_LEN-1
- cfg_sym  in  SYM_W  pattern symbol data
- cfg_len_we  in  1  write cfg_len to the length register
- cfg_len  in  3  pattern length, legal 1..MAX_LEN
- match_limit  in  CNT_W  matches before auto-stop; 0 = unlimited; sampled at start
- start  in  1  arm scan (pulse)
- stop  in  1  abort scan (pulse)
- sym_valid  in  1  sym_in is valid this cycle
- sym_in  in  SYM_W  input symbol
- busy  out  1  high in ARMED
- pos  out  3  symbols of the pattern currently matched, 0..len-1
- match  out  1  one-cycle pulse per complete match
- match_count  out  CNT_W  matches since last start, saturating
- done  out  1  one-cycle pulse when the limit is reached
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- Registers: pat[0..MAX_LEN-1], len, limit_q, pos, match_count, state.
- States: IDLE, ARMED, DONE.
- IDLE: cfg_we/cfg_len_we accepted. On start: if len is 0 or greater than MAX_LEN, stay in IDLE and pulse cfg_err. Otherwise clear pos and match_count, latch limit_q from match_limit, and go to ARMED.
- ARMED: cfg writes ignored; start ignored. Per sym_valid cycle:
  - sym_in == pat[pos]: if pos == len-1, pulse match, increment match_count (saturating at all-ones), set pos=0 (non-overlapping); else pos+1.
  - mismatch: pos = 1 if sym_in == pat[0], else 0. This recovery is fixed: no longer-prefix search.
  - If the increment makes match_count == limit_q (limit_q != 0), go to DONE.
- DONE: pulse done for one cycle, then go to IDLE. match_count holds until the next start.
- stop in ARMED: go to IDLE; pos=0; no match/done. A symbol in the same cycle is discarded (stop wins).
- sym_valid low: no state change.
- reset: state=IDLE; pat[*]=0; len=0; pos=0; match_count=0; limit_q=0; busy, match, done, and cfg_err are 0.

## Timing
- All outputs are registered.
- match, match_count update, and pos update appear in the cycle after the accepting symbol is sampled.
- busy rises the cycle after start and falls the cycle after stop, or on the cycle done is asserted.
- done is asserted the cycle after the match that reaches the limit. It coincides with the state being DONE, one cycle after that match pulse. busy is low while done is high.
- cfg_err is asserted the cycle after a rejected start.
- Back-to-back symbols are accepted every cycle. There is no backpressure.
- reset asserted mid-scan takes priority over everything else in that cycle.

## Test plan
- Load pat=2,5,2,5, len=4, limit=0, start; stream 2,5,2,5,2,5,2,5 -> match pulses after symbols 4 and 8; match_count=2; busy stays 1.
- Same pattern; stream 2,2,5,2,5 -> mismatch at symbol 2 recovers pos=1; match after symbol 5; match_count=1.
- len=2, pat=3,4, limit=3; stream 3,4 three times -> third match is followed next cycle by a done pulse, busy=0, match_count=3; further symbols produce no matches.
- len=0 then start -> cfg_err pulse; busy stays 0. Start after cfg_len=5 -> cfg_err.
- ARMED with pos=2, assert stop with sym_valid=1 and the completing symbol -> no match; pos=0; busy=0 next cycle. cfg_we during ARMED leaves pat unchanged (verify by rescan).
- Assert reset mid-scan with match_count=1 -> next cycle all outputs 0, len=0; a start then yields cfg_err.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Run-time programmable symbol-sequence scanner: host loads a pattern and a match limit,
// arms the block, and it counts non-overlapping matches until stopped or the limit is hit.
module pattern_scan_ctrl #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0]   cfg_addr,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic                         cfg_len_we,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]             match_limit,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         sym_valid,
  input  logic [SYM_W-1:0]             sym_in,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] pos,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         done,
  output logic                         cfg_err,
  output logic [1:0]                   state_dbg
);

  localparam int AW    = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SYM_W-1:0]   r_pat [MAX_LEN];
  logic [LEN_W-1:0]   r_len, r_pos, w_pos_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, r_limit_q, w_limit_nxt;
  logic               r_busy, r_match, r_done, r_cfg_err;
  logic               w_match_nxt, w_cfg_err_nxt, w_pat_we, w_len_we;
  logic               w_len_ok, w_last, w_hit;
  logic [SYM_W-1:0]   w_pat_cur;

  assign w_pat_cur = r_pat[r_pos[AW-1:0]];
  assign w_len_ok  = (r_len != '0) && (r_len <= LEN_W'(MAX_LEN));
  assign w_last    = (r_pos == (r_len - LEN_W'(1)));
  // A match pulse with count equal to a non-zero limit means the limit was just reached.
  assign w_hit     = r_match && (r_limit_q != '0) && (r_cnt == r_limit_q);

  // sym_valid qualifies sym_in; there is no ready, a valid symbol is consumed every cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_cnt_nxt     = r_cnt;
    w_limit_nxt   = r_limit_q;
    w_match_nxt   = 1'b0;
    w_cfg_err_nxt = 1'b0;
    w_pat_we      = 1'b0;
    w_len_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pat_we = cfg_we;
        w_len_we = cfg_len_we;
        if (start) begin
          if (w_len_ok) begin
            w_state_nxt = S_ARMED;
            w_pos_nxt   = '0;
            w_cnt_nxt   = '0;
            w_limit_nxt = match_limit;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_pos_nxt   = '0;
        end else if (w_hit) begin
          w_state_nxt = S_DONE;
          w_pos_nxt   = '0;
        end else if (sym_valid) begin
          if (sym_in == w_pat_cur) begin
            if (w_last) begin
              w_match_nxt = 1'b1;
              w_pos_nxt   = '0;
              w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            end else begin
              w_pos_nxt = r_pos + LEN_W'(1);
            end
          end else begin
            w_pos_nxt = (sym_in == r_pat[0]) ? LEN_W'(1) : '0;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) r_pat[i] <= '0;
      r_len     <= '0;
      r_pos     <= '0;
      r_cnt     <= '0;
      r_limit_q <= '0;
      r_busy    <= 1'b0;
      r_match   <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_cnt     <= w_cnt_nxt;
      r_limit_q <= w_limit_nxt;
      r_busy    <= (w_state_nxt == S_ARMED);
      r_match   <= w_match_nxt;
      r_done    <= (w_state_nxt == S_DONE);
      r_cfg_err <= w_cfg_err_nxt;
      if (w_pat_we) r_pat[cfg_addr] <= cfg_sym;
      if (w_len_we) r_len <= cfg_len;
    end
  end

  assign busy        = r_busy;
  assign pos         = r_pos;
  assign match       = r_match;
  assign match_count = r_cnt;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;
  assign state_dbg   = r_state;

endmodule
